reg_bank_ctrl: RTL
==================

REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: register/data width, a multiple of 8 in the range 8..64.
REQ-002 The block SHALL have parameter ADDR_W, default 8: address width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16: register count, 2..2**ADDR_W; index NUM_REGS-1 is the LOCK register.
REQ-004 The block SHALL have parameter WAIT_CYC, default 0: inserted wait states per access, 0..15.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: access request.
REQ-008 The block SHALL have port wr, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port addr, input, ADDR_W bits: register index.
REQ-010 The block SHALL have port wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port wstrb, input, DATA_W/8 bits: byte-lane write enables.
REQ-012 The block SHALL have port rdata, output, DATA_W bits: read data.
REQ-013 The block SHALL have port rdy, output, 1 bit: one-cycle access-complete pulse.
REQ-014 The block SHALL have port err, output, 1 bit: error flag, valid only while rdy=1.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 In IDLE, en=1 SHALL capture wr/addr/wdata/wstrb, then go to WAIT if WAIT_CYC>0, otherwise to RESP.
REQ-017 WAIT SHALL last exactly WAIT_CYC cycles, counted by a down-counter, then go to RESP.
REQ-018 RESP SHALL last one cycle with rdy=1, then always return to IDLE.
REQ-019 Latency: en sampled in cycle c SHALL give rdy=1 in cycle c+1+WAIT_CYC; max throughput is one access per WAIT_CYC+2 cycles.
REQ-020 Request inputs SHALL be ignored outside IDLE; en dropping or inputs changing mid-access SHALL NOT affect the captured access.
REQ-021 A write SHALL commit in the RESP cycle, updating only the byte lanes with wstrb[i]=1.
REQ-022 wstrb=0 on an in-range write SHALL complete with err=0 and change no register.
REQ-023 A read SHALL drive rdata with the register value in RESP; rdata SHALL hold its value until the next read response.
REQ-024 The LOCK register SHALL implement bit0 only, read back as {zeros, lock}; a write updates it only when wstrb[0]=1.
REQ-025 With lock=1, a write to indices 0..NUM_REGS-2 SHALL leave the register unchanged and give err=1; the LOCK register SHALL always be writable.
REQ-026 Reads SHALL never be blocked by lock.
REQ-027 addr>=NUM_REGS SHALL give err=1; such a read returns rdata=0 and such a write has no effect.
REQ-028 err SHALL be 0 whenever rdy=0.

Reset
REQ-029 With rstn=0 at a rising clk edge: state=IDLE, wait counter=0, all registers=0 (lock=0), rdata=0, rdy=0, err=0.
REQ-030 Reset during WAIT or RESP SHALL abort the access with no write commit and no rdy pulse.

Structure
REQ-031 Package reg_bank_pkg SHALL hold the state enum typedef, LOCK_BIT=0, and the parameter default constants.
REQ-032 The block SHALL contain one sub-module, reg_bank_regfile: storage, strobe-masked write and read mux.

Verification
REQ-033 After reset, read addr 0..15 (WAIT_CYC=0): each gives rdy one cycle after en, rdata=0x00, err=0.
REQ-034 Write 0xA5 to addr 3 with wstrb=1, then read addr 3: rdata=0xA5, err=0; with WAIT_CYC=3, rdy comes 4 cycles after en.
REQ-035 DATA_W=32: write 0x11223344 with wstrb=4'b0101 over 0, then read: rdata=0x00220044.
REQ-036 Write 0x01 to addr 15 (lock), then write 0xFF to addr 2: err=1 and addr 2 still reads 0x00; write 0x00 to addr 15, then the same write succeeds.
REQ-037 Read addr 0x20 (NUM_REGS=16): rdata=0, err=1; write to addr 0x20: err=1, no register changes.
REQ-038 With WAIT_CYC=2, assert rstn=0 in the WAIT cycle of a write of 0x5A to addr 1: no rdy pulse, addr 1 reads 0x00 afterwards.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the register bank controller.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bit position of the lock flag inside the LOCK register
    localparam int LOCK_BIT = 0;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 8;
    localparam int NUM_REGS_DEF = 16;
    localparam int WAIT_CYC_DEF = 0;

    // True when a register index addresses an implemented register
    function automatic logic in_range(input int unsigned a, input int unsigned n);
        return (a < n);
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Request/response bus between a host and the register bank.
interface reg_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                en;
    logic                wr;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                rdy;
    logic                err;

    modport master (
        output en, wr, addr, wdata, wstrb,
        input  rdata, rdy, err
    );

    modport slave (
        input  en, wr, addr, wdata, wstrb,
        output rdata, rdy, err
    );
endinterface

// File: rtl/reg_bank_regfile.sv
// Register storage with byte-lane masked writes, the LOCK flag and the read mux.
module reg_bank_regfile
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                lock
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'(NUM_REGS - 1);

    logic [DATA_W-1:0] regs [NUM_REGS-1];
    logic [IDX_W-1:0]  idx;
    logic              hit;

    assign idx = addr[IDX_W-1:0];
    assign hit = in_range(int'(addr), NUM_REGS);

    // Storage update: byte lanes of ordinary registers, single-bit LOCK register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
            lock <= 1'b0;
        end else if (we && hit) begin
            if (idx == LOCK_IDX) begin
                if (wstrb[LOCK_BIT/8]) begin
                    lock <= wdata[LOCK_BIT];
                end
            end else begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (idx == IDX_W'(i)) begin
                        for (int b = 0; b < NB; b++) begin
                            if (wstrb[b]) begin
                                regs[i][8*b +: 8] <= wdata[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // Read mux: unimplemented indices return zero, LOCK reads back as a single bit
    always_comb begin
        rdata = '0;
        if (hit) begin
            if (idx == LOCK_IDX) begin
                rdata[LOCK_BIT] = lock;
            end else begin
                for (int i = 0; i < NUM_REGS - 1; i++) begin
                    if (idx == IDX_W'(i)) begin
                        rdata = regs[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank access controller: captures one request, waits, then responds for one cycle.
module reg_bank_ctrl
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic     clk,
    input  logic     rstn,
    reg_bank_if.slave bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_RESP = ST_RESP;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(NUM_REGS - 1);

    logic [1:0]          state;
    logic [3:0]          wait_cnt;
    logic                cap_wr;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [DATA_W/8-1:0] cap_wstrb;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   rd_val;
    logic                lock;
    logic                hit;
    logic                blocked;
    logic                acc_err;
    logic                resp;
    logic                commit;

    // Access sequencing: capture in IDLE, count wait states down, respond for one cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        cap_wr    <= bus.wr;
                        cap_addr  <= bus.addr;
                        cap_wdata <= bus.wdata;
                        cap_wstrb <= bus.wstrb;
                        if (WAIT_CYC > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    if (!cap_wr) begin
                        rdata_q <= rd_val;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Response decode; gated by rstn so a reset in the response cycle suppresses the pulse
    always_comb begin
        hit       = in_range(int'(cap_addr), NUM_REGS);
        blocked   = cap_wr && lock && (cap_addr != LOCK_ADDR);
        acc_err   = !hit || blocked;
        resp      = (state == S_RESP) && rstn;
        commit    = resp && cap_wr && !acc_err;
        bus.rdy   = resp;
        bus.err   = resp && acc_err;
        bus.rdata = (resp && !cap_wr) ? rd_val : rdata_q;
    end

    reg_bank_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk   (clk),
        .rstn  (rstn),
        .we    (commit),
        .addr  (cap_addr),
        .wdata (cap_wdata),
        .wstrb (cap_wstrb),
        .rdata (rd_val),
        .lock  (lock)
    );

endmodule
